// File: rtl/instr_encode_loader.sv
// MIPS-style instruction encoder feeding a 4-deep word FIFO, drained by a
// write FSM into instruction memory at consecutive word addresses.
module instr_encode_loader (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [4:0]  req_rs_i,
    input  logic [4:0]  req_rt_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_shamt_i,
    input  logic [5:0]  req_funct_i,
    input  logic [15:0] req_imm_i,
    input  logic [25:0] req_target_i,
    input  logic        load_start_i,
    input  logic [31:0] start_addr_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic [7:0]  count_o,
    output logic        err_o
);

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_ADDI  = 4'd1,
        OP_SLTIU = 4'd2,
        OP_BEQ   = 4'd3,
        OP_LUI   = 4'd4,
        OP_ORI   = 4'd5,
        OP_BNE   = 4'd6,
        OP_LW    = 4'd7,
        OP_SW    = 4'd8,
        OP_BLEZ  = 4'd9,
        OP_BGTZ  = 4'd10,
        OP_JRS   = 4'd11,
        OP_J     = 4'd12,
        OP_JAL   = 4'd13
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_SLTIU   = 6'b001011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_BNE     = 6'b000101;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_BLEZ    = 6'b000110;
    localparam logic [5:0] OPC_BGTZ    = 6'b000111;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_fifo [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [7:0]  r_count;
    logic        r_err;

    logic [31:0] w_word;
    logic        w_illegal;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_load;
    logic [2:0]  w_cnt_next;

    always_comb begin
        w_word    = '0;
        w_illegal = 1'b0;
        case (req_op_i)
            OP_RTYPE: w_word = {OPC_SPECIAL, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i};
            OP_ADDI:  w_word = {OPC_ADDI,  req_rs_i, req_rt_i, req_imm_i};
            OP_SLTIU: w_word = {OPC_SLTIU, req_rs_i, req_rt_i, req_imm_i};
            OP_BEQ:   w_word = {OPC_BEQ,   req_rs_i, req_rt_i, req_imm_i};
            OP_LUI:   w_word = {OPC_LUI,   5'd0,     req_rt_i, req_imm_i};
            OP_ORI:   w_word = {OPC_ORI,   req_rs_i, req_rt_i, req_imm_i};
            OP_BNE:   w_word = {OPC_BNE,   req_rs_i, req_rt_i, req_imm_i};
            OP_LW:    w_word = {OPC_LW,    req_rs_i, req_rt_i, req_imm_i};
            OP_SW:    w_word = {OPC_SW,    req_rs_i, req_rt_i, req_imm_i};
            OP_BLEZ:  w_word = {OPC_BLEZ,  req_rs_i, 5'd0,     req_imm_i};
            OP_BGTZ:  w_word = {OPC_BGTZ,  req_rs_i, 5'd0,     req_imm_i};
            OP_JRS:   w_word = {OPC_SPECIAL, req_rs_i, 15'd0, FUNCT_JR};
            OP_J:     w_word = {OPC_J,     req_target_i};
            OP_JAL:   w_word = {OPC_JAL,   req_target_i};
            default:  w_illegal = 1'b1;
        endcase
    end

    // Illegal ops are still handshaken so a bad request never stalls the producer.
    assign req_ready_o = rst_n && (r_cnt != 3'd4);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_push      = w_accept && !w_illegal;
    assign w_pop       = (r_state == ST_WRITE) && mem_ack_i;
    assign w_load      = load_start_i && (r_state == ST_IDLE) && (r_cnt == 3'd0);
    assign w_cnt_next  = r_cnt + {2'b00, w_push} - {2'b00, w_pop};

    always_comb begin
        w_state_next = r_state;
        mem_we_o     = 1'b0;
        mem_wdata_o  = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_cnt != 3'd0) w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we_o    = 1'b1;
                mem_wdata_o = r_fifo[r_rd_ptr];
                if (mem_ack_i && (w_cnt_next == 3'd0)) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal;
            r_cnt <= w_cnt_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            if (w_load) begin
                r_addr  <= start_addr_i;
                r_count <= '0;
            end else if (w_pop) begin
                r_addr <= r_addr + 32'd4;
                if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through an occupied slot.
    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_word;
    end

    assign mem_addr_o = r_addr;
    assign count_o    = r_count;
    assign err_o      = r_err;
    assign busy_o     = (r_state == ST_WRITE) || (r_cnt != 3'd0);

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encoding table plus FIFO/address/reset corner sequences.
module tb_instr_encode_loader;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_op_i;
    logic [4:0]  req_rs_i, req_rt_i, req_rd_i, req_shamt_i;
    logic [5:0]  req_funct_i;
    logic [15:0] req_imm_i;
    logic [25:0] req_target_i;
    logic        load_start_i;
    logic [31:0] start_addr_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic        busy_o;
    logic [7:0]  count_o;
    logic        err_o;

    instr_encode_loader dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_rs_i     (req_rs_i),
        .req_rt_i     (req_rt_i),
        .req_rd_i     (req_rd_i),
        .req_shamt_i  (req_shamt_i),
        .req_funct_i  (req_funct_i),
        .req_imm_i    (req_imm_i),
        .req_target_i (req_target_i),
        .load_start_i (load_start_i),
        .start_addr_i (start_addr_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .busy_o       (busy_o),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [14];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_addr;
    logic [7:0]  m_count;

    function automatic vec_t mkv(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
        v.fn = fn; v.imm = imm; v.tgt = tgt; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        req_op_i = v.op; req_rs_i = v.rs; req_rt_i = v.rt; req_rd_i = v.rd;
        req_shamt_i = v.sh; req_funct_i = v.fn; req_imm_i = v.imm; req_target_i = v.tgt;
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic push_one(input string name, input vec_t v);
        check({name, " ready"}, {31'b0, req_ready_o}, 32'd1);
        apply(v);
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic load_base(input logic [31:0] a);
        load_start_i = 1'b1;
        start_addr_i = a;
        @(negedge clk_i);
        load_start_i = 1'b0;
        m_addr  = a;
        m_count = 8'd0;
    endtask

    task automatic expect_write(input string name, input logic [31:0] exp);
        int unsigned waited = 0;
        while (mem_we_o !== 1'b1 && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        if (mem_we_o !== 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: mem_we_o got %b, expected 1", name, mem_we_o);
        end else begin
            check({name, " addr"}, mem_addr_o, m_addr);
            check({name, " data"}, mem_wdata_o, exp);
            mem_ack_i = 1'b1;
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            m_addr = m_addr + 32'd4;
            if (m_count != 8'hFF) m_count = m_count + 8'd1;
            check({name, " count"}, {24'b0, count_o}, {24'b0, m_count});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        // Unused fields carry non-zero junk so any leakage into the word shows up.
        vecs[0]  = mkv(4'd0,  5'd1,  5'd2,  5'd3,  5'd4,  6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h00221920);
        vecs[1]  = mkv(4'd1,  5'd2,  5'd3,  5'd31, 5'd31, 6'h3F, 16'h0010, 26'h3FFFFFF, 32'h20430010);
        vecs[2]  = mkv(4'd2,  5'd5,  5'd6,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h2CA6FFFF);
        vecs[3]  = mkv(4'd3,  5'd1,  5'd2,  5'd31, 5'd31, 6'h3F, 16'h8000, 26'h3FFFFFF, 32'h10228000);
        vecs[4]  = mkv(4'd4,  5'd7,  5'd1,  5'd31, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF, 32'h3C011234);
        vecs[5]  = mkv(4'd5,  5'd4,  5'd4,  5'd31, 5'd31, 6'h3F, 16'h00FF, 26'h3FFFFFF, 32'h348400FF);
        vecs[6]  = mkv(4'd6,  5'd3,  5'd0,  5'd31, 5'd31, 6'h3F, 16'hFFFE, 26'h3FFFFFF, 32'h1460FFFE);
        vecs[7]  = mkv(4'd7,  5'd29, 5'd8,  5'd31, 5'd31, 6'h3F, 16'h0004, 26'h3FFFFFF, 32'h8FA80004);
        vecs[8]  = mkv(4'd8,  5'd29, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0008, 26'h3FFFFFF, 32'hAFBF0008);
        vecs[9]  = mkv(4'd9,  5'd9,  5'd5,  5'd31, 5'd31, 6'h3F, 16'h0003, 26'h3FFFFFF, 32'h19200003);
        vecs[10] = mkv(4'd10, 5'd10, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFF0, 26'h3FFFFFF, 32'h1D40FFF0);
        vecs[11] = mkv(4'd11, 5'd31, 5'd7,  5'd7,  5'd7,  6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h03E00008);
        vecs[12] = mkv(4'd13, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000040, 32'h0C000040);
        vecs[13] = mkv(4'd12, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF);

        rst_n = 1'b0; req_valid_i = 1'b0; load_start_i = 1'b0; start_addr_i = '0; mem_ack_i = 1'b0;
        apply(vecs[0]);
        m_addr = '0; m_count = '0;
        repeat (3) @(negedge clk_i);
        check("reset ready", {31'b0, req_ready_o}, 32'd0);
        check("reset we",    {31'b0, mem_we_o},    32'd0);
        check("reset busy",  {31'b0, busy_o},      32'd0);
        check("reset err",   {31'b0, err_o},       32'd0);
        check("reset count", {24'b0, count_o},     32'd0);
        check("reset addr",  mem_addr_o,           32'd0);
        check("reset wdata", mem_wdata_o,          32'd0);
        rst_n = 1'b1;
        @(negedge clk_i);
        check("post-reset ready", {31'b0, req_ready_o}, 32'd1);

        // Base load then a single ADDI, checking the one-cycle write latency.
        load_base(32'h0000_0100);
        check("load addr", mem_addr_o, 32'h0000_0100);
        push_one("addi", vecs[1]);
        check("addi latency we0", {31'b0, mem_we_o}, 32'd0);
        check("addi busy", {31'b0, busy_o}, 32'd1);
        @(negedge clk_i);
        check("addi latency we1", {31'b0, mem_we_o}, 32'd1);
        expect_write("addi", 32'h20430010);
        check("addi idle we", {31'b0, mem_we_o}, 32'd0);

        // Ack while idle must be ignored.
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        check("idle ack count", {24'b0, count_o}, {24'b0, m_count});
        check("idle ack addr", mem_addr_o, m_addr);

        for (int i = 0; i < 14; i++) begin
            push_one($sformatf("vec%0d", i), vecs[i]);
            check($sformatf("vec%0d we0", i), {31'b0, mem_we_o}, 32'd0);
            @(negedge clk_i);
            expect_write($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Fill the FIFO with no acks; the fifth request waits for a pop.
        for (int k = 0; k < 4; k++) begin
            check($sformatf("full ready%0d", k), {31'b0, req_ready_o}, 32'd1);
            v = mkv(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00A0 + 16'(k), 26'd0, 32'd0);
            apply(v);
            req_valid_i = 1'b1;
            @(negedge clk_i);
        end
        check("full ready low", {31'b0, req_ready_o}, 32'd0);
        check("full head", mem_wdata_o, 32'h202200A0);
        v = mkv(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00A4, 26'd0, 32'd0);
        apply(v);
        @(negedge clk_i);
        check("full stall", {31'b0, req_ready_o}, 32'd0);
        check("full stall addr", mem_addr_o, m_addr);
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        m_addr = m_addr + 32'd4;
        m_count = m_count + 8'd1;
        check("full ready after pop", {31'b0, req_ready_o}, 32'd1);
        check("full next head", mem_wdata_o, 32'h202200A1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("full refilled", {31'b0, req_ready_o}, 32'd0);
        check("full count", {24'b0, count_o}, {24'b0, m_count});
        for (int k = 1; k < 5; k++)
            expect_write($sformatf("full drain%0d", k), 32'h202200A0 + 32'(k));

        // Address wrap at the top of the space.
        load_base(32'hFFFF_FFFC);
        check("wrap count cleared", {24'b0, count_o}, 32'd0);
        push_one("wrap lui0", vecs[4]);
        push_one("wrap lui1", vecs[4]);
        expect_write("wrap0", 32'h3C011234);
        expect_write("wrap1", 32'h3C011234);
        check("wrap addr zero", mem_addr_o, 32'h0000_0004);

        // Base load while a write is pending must not disturb the address.
        push_one("busy push", vecs[5]);
        @(negedge clk_i);
        load_start_i = 1'b1;
        start_addr_i = 32'h5555_0000;
        @(negedge clk_i);
        load_start_i = 1'b0;
        check("busy load ignored", mem_addr_o, m_addr);
        expect_write("busy write", 32'h348400FF);

        // Illegal ops: accepted, one-cycle err pulse, nothing written.
        for (int k = 14; k < 16; k++) begin
            v = mkv(4'(k), 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 32'd0);
            push_one($sformatf("illegal%0d", k), v);
            check($sformatf("illegal%0d err", k), {31'b0, err_o}, 32'd1);
            check($sformatf("illegal%0d busy", k), {31'b0, busy_o}, 32'd0);
            @(negedge clk_i);
            check($sformatf("illegal%0d err drop", k), {31'b0, err_o}, 32'd0);
            check($sformatf("illegal%0d we", k), {31'b0, mem_we_o}, 32'd0);
            check($sformatf("illegal%0d count", k), {24'b0, count_o}, {24'b0, m_count});
        end

        // Reset in the middle of a write with three words queued.
        for (int k = 0; k < 3; k++) begin
            apply(vecs[k]);
            req_valid_i = 1'b1;
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        check("pre-reset we", {31'b0, mem_we_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk_i);
        check("midreset we",    {31'b0, mem_we_o},    32'd0);
        check("midreset busy",  {31'b0, busy_o},      32'd0);
        check("midreset count", {24'b0, count_o},     32'd0);
        check("midreset ready", {31'b0, req_ready_o}, 32'd0);
        check("midreset addr",  mem_addr_o,           32'd0);
        rst_n = 1'b1;
        m_addr = '0;
        m_count = '0;
        @(negedge clk_i);
        check("after reset busy", {31'b0, busy_o}, 32'd0);
        check("after reset we", {31'b0, mem_we_o}, 32'd0);
        push_one("after reset push", vecs[6]);
        expect_write("after reset write", 32'h1460FFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
